pci_target: RTL and testbench
=============================

Name: pci_target

Overview:
- Dedicated PCI-style bus target (responder) for the shared bus driven by the initiator-capable `device` blocks and granted by `ARBITER`.
- Decodes the address phase and claims the transaction with `devsel`.
- Completes write or read bursts into or out of an internal word memory, incrementing the address each data phase.
- Releases the shared lines cleanly and exposes a debug read port for verification.

Parameters:
- BASE_ADDR, 20: first word address claimed by this target.
- DEPTH, 16: number of 32-bit memory words; claimed range is BASE_ADDR .. BASE_ADDR+DEPTH-1.
- IDX_W, 4: index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  bus clock; all sampling and driving on posedge.
- rst  input  1  asynchronous, active-high reset.
- AD  inout  32  address phase: word address from initiator; data phase: write data in, read data out.
- CBE  input  4  address phase: command, 4'b1000 = write, 4'b0000 = read; data phase: active-high byte enables, bit i enables AD[8i+7:8i].
- iframe  input  1  active-low; low = transaction in progress; high while iready is low = final data phase.
- iready  input  1  active-low initiator ready.
- tready  output  1  active-low target ready; tri-stated (z) when not claimed.
- devsel  output  1  active-low device select; tri-stated when not claimed.
- dbg_addr  input  IDX_W  debug memory index.
- dbg_data  output  32  combinational memory[dbg_addr].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - tready, devsel and AD are tri-stated.
  - busy = 0, index = 0, all memory words = 0.
  - A mid-burst reset drops the transfer; words already written are cleared.
- States: IDLE, WDATA, RTURN, RDATA, BACKOFF.
- IDLE:
  - On a posedge with iframe==0, the previous sampled iframe==1, and BASE_ADDR <= AD < BASE_ADDR+DEPTH:
    - latch idx = AD - BASE_ADDR (low IDX_W bits).
    - CBE==4'b1000: go to WDATA; drive devsel=0 and tready=0 from this edge.
    - CBE==4'b0000: go to RTURN; drive devsel=0 and tready=1; AD not driven.
  - Any other CBE, or an address miss: stay in IDLE, drive nothing.
  - Address-to-devsel latency is 1 clock.
- WDATA:
  - Transfer edge (sampled iready==0 and tready==0): for each i with CBE[i]==1, memory[idx] byte i <= AD byte i; then idx <= idx+1, wrapping DEPTH-1 -> 0.
  - If iframe==1 on the transfer edge, this is the last phase: go to BACKOFF.
  - iready==1 with iframe==0 is an initiator wait state: hold, no write.
- RTURN:
  - One turnaround clock, then go to RDATA.
  - Enable the AD driver with memory[idx]; drive tready=0.
- RDATA:
  - AD always shows memory[idx].
  - Transfer edge: idx <= idx+1 (wrap); AD shows the new word from the next clock.
  - iframe==1 on the transfer edge: go to BACKOFF and release AD on that edge.
  - Wait states hold AD stable.
- Abort: in WDATA or RDATA, sampled iframe==1 and iready==1 (initiator vanished): go to BACKOFF with no transfer.
- BACKOFF:
  - One clock driving tready=1 and devsel=1.
  - AD tri-stated; next edge tri-states tready and devsel and returns to IDLE.
  - A new address phase is not decoded in BACKOFF; it is decoded from IDLE on the next edge.
- Never drive AD in IDLE, WDATA, RTURN or BACKOFF. This guarantees no contention with the initiator.
- Memory is written only in WDATA. dbg_data is purely combinational.

Test Plan:
- Reset: assert rst=1 mid-clock -> tready, devsel, AD read z immediately; busy=0; dbg_data=0 for all indices.
- Single write: iframe=0, AD=22, CBE=4'b1000; next clock iframe=1, iready=0, AD=32'hDEADBEEF, CBE=4'b1111 -> devsel and tready low 1 clock after the address; dbg_addr=2 gives 32'hDEADBEEF; BACKOFF drives tready/devsel high, then z.
- Burst write with byte enables and wait state: address 20, data 32'h11111111 (CBE 4'b1111), one iready=1 clock, 32'hAABBCCDD (CBE 4'b0011) last -> mem[0]=32'h11111111; mem[1]=32'h0000CCDD; no write during the wait clock.
- Burst read with wrap: preload mem[15]=32'hA5A5A5A5 and mem[0]=32'h5A5A5A5A; read at address 35 -> one RTURN clock with AD z, then AD=32'hA5A5A5A5, then 32'h5A5A5A5A after the first transfer; AD released on the last transfer.
- Decode misses: address 19, address 36, and address 20 with CBE=4'b0110 -> devsel and tready stay z, busy=0, memory unchanged.
- Abort and reset mid-burst: start a write at 20, drive iframe=1 and iready=1 in WDATA -> BACKOFF then IDLE with no write. Separately, assert rst during RDATA -> AD z asynchronously and state IDLE.

Source files
------------

// File: rtl/pci_target_if.sv
// rtl/pci_target_if.sv - shared PCI-style bus lines with per-side tri-state drivers
interface pci_target_if;
    tri   [31:0] AD;
    logic [3:0]  CBE;
    logic        iframe;
    logic        iready;
    tri          tready;
    tri          devsel;

    // Initiator-side driver for AD
    logic [31:0] i_ad;
    logic        i_ad_en;

    // Target-side drivers; tready and devsel are always released together
    logic [31:0] t_ad;
    logic        t_ad_en;
    logic        t_tready;
    logic        t_devsel;
    logic        t_ctl_en;

    assign AD     = i_ad_en  ? i_ad     : 'z;
    assign AD     = t_ad_en  ? t_ad     : 'z;
    assign tready = t_ctl_en ? t_tready : 1'bz;
    assign devsel = t_ctl_en ? t_devsel : 1'bz;

    modport master (
        output i_ad, i_ad_en, CBE, iframe, iready,
        input  AD, tready, devsel
    );

    modport slave (
        input  AD, CBE, iframe, iready,
        output t_ad, t_ad_en, t_tready, t_devsel, t_ctl_en
    );
endinterface

// File: rtl/pci_target.sv
// rtl/pci_target.sv - PCI-style bus target: address decode, write/read bursts into a word memory
module pci_target #(
    parameter int unsigned BASE_ADDR = 20,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    pci_target_if.slave      bus,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [31:0]      dbg_data,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, WDATA, RTURN, RDATA, BACKOFF} state_t;

    localparam logic [32:0] ADDR_LO   = 33'(BASE_ADDR);
    localparam logic [32:0] ADDR_HI   = 33'(BASE_ADDR) + 33'(DEPTH);
    localparam logic [3:0]  CMD_WRITE = 4'b1000;
    localparam logic [3:0]  CMD_READ  = 4'b0000;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic             iframe_q;
    logic [31:0]      mem [DEPTH];
    logic             addr_hit;
    logic             start;
    logic             xfer;

    assign addr_hit = ({1'b0, bus.AD} >= ADDR_LO) && ({1'b0, bus.AD} < ADDR_HI);
    assign start    = (state == IDLE) && !bus.iframe && iframe_q && addr_hit &&
                      ((bus.CBE == CMD_WRITE) || (bus.CBE == CMD_READ));
    // tready is held low by this target in both data states, so iready alone qualifies a transfer
    assign xfer     = ((state == WDATA) || (state == RDATA)) && !bus.iready;
    assign idx_inc  = (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (bus.CBE == CMD_WRITE) ? WDATA : RTURN;
                end
            end
            // iframe high ends the burst: either the final transfer or an abort with iready high
            WDATA, RDATA: begin
                if (bus.iframe) begin
                    state_nxt = BACKOFF;
                end
            end
            RTURN:   state_nxt = RDATA;
            BACKOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.t_ctl_en = 1'b0;
        bus.t_tready = 1'b1;
        bus.t_devsel = 1'b1;
        bus.t_ad_en  = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
            end
            WDATA: begin
                bus.t_ctl_en = 1'b1;
                bus.t_tready = 1'b0;
                bus.t_devsel = 1'b0;
                busy         = 1'b1;
            end
            RTURN: begin
                bus.t_ctl_en = 1'b1;
                bus.t_devsel = 1'b0;
                busy         = 1'b1;
            end
            RDATA: begin
                bus.t_ctl_en = 1'b1;
                bus.t_tready = 1'b0;
                bus.t_devsel = 1'b0;
                bus.t_ad_en  = 1'b1;
                busy         = 1'b1;
            end
            BACKOFF: begin
                bus.t_ctl_en = 1'b1;
                busy         = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            iframe_q <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            iframe_q <= bus.iframe;
            if (start) begin
                // Low bits of the difference only depend on the low bits of the operands
                idx <= bus.AD[IDX_W-1:0] - IDX_W'(BASE_ADDR);
            end else if (xfer) begin
                if (state == WDATA) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.CBE[b]) begin
                            mem[idx][8*b +: 8] <= bus.AD[8*b +: 8];
                        end
                    end
                end
                idx <= idx_inc;
            end
        end
    end

    assign bus.t_ad = mem[idx];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: tb/tb_pci_target.sv
// tb/tb_pci_target.sv - randomized scoreboard bench for pci_target
`timescale 1ns/1ps
module tb_pci_target;
    localparam int BASE  = 20;
    localparam int DEPTH = 16;

    typedef struct {
        bit is_wr;
        int cyc;
    } claim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        busy;

    pci_target_if bus ();

    pci_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .IDX_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] rd_q [$];
    claim_t      claim_q [$];
    logic [31:0] ph_data [$];
    logic [3:0]  ph_be [$];
    int          ph_wait [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Scoreboard monitor: claims and read data are matched against queued expectations
    bit claimed_prev = 1'b0;
    always @(negedge clk) begin
        bit     claimed;
        claim_t c;
        claimed = bus.t_ctl_en && (bus.devsel === 1'b0);
        if (claimed && !claimed_prev) begin
            check("claim_expected", 32'(claim_q.size() != 0), 32'd1);
            if (claim_q.size() != 0) begin
                c = claim_q.pop_front();
                check("claim_latency", 32'(cyc), 32'(c.cyc));
                check("claim_tready", 32'(bus.tready), c.is_wr ? 32'd0 : 32'd1);
            end
        end
        claimed_prev = claimed;
        if (bus.t_ad_en) begin
            check("rdata_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                check("rdata", bus.AD, rd_q[0]);
                if (bus.iready === 1'b0) void'(rd_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.iframe  = 1'b1;
        bus.iready  = 1'b1;
        bus.i_ad_en = 1'b0;
        bus.i_ad    = '0;
        bus.CBE     = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic verify_mem();
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = 4'(i);
            #0.1;
            check("mem", dbg_data, model[i]);
        end
    endtask

    task automatic check_released(string name);
        check(name, {29'd0, bus.t_ctl_en, bus.t_ad_en, busy}, 32'd0);
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd, input bit expect_claim, input bit is_wr);
        bus.iframe  = 1'b0;
        bus.iready  = 1'b1;
        bus.i_ad_en = 1'b1;
        bus.i_ad    = a;
        bus.CBE     = cmd;
        if (expect_claim) claim_q.push_back('{is_wr, cyc + 1});
        tick();
    endtask

    task automatic backoff_check();
        idle_bus();
        check("backoff_en", {30'd0, bus.t_ctl_en, bus.t_ad_en}, 32'd2);
        check("backoff_lines", {30'd0, bus.tready, bus.devsel}, 32'd3);
        check("backoff_busy", 32'(busy), 32'd1);
        tick();
        check_released("idle_release");
    endtask

    task automatic write_txn(input logic [31:0] a);
        int off;
        off = int'(a) - BASE;
        addr_phase(a, 4'b1000, 1'b1, 1'b1);
        for (int k = 0; k < ph_data.size(); k++) begin
            for (int w = 0; w < ph_wait[k]; w++) begin
                bus.iframe = 1'b0;
                bus.iready = 1'b1;
                bus.i_ad   = $urandom;
                bus.CBE    = 4'($urandom);
                tick();
            end
            bus.iready = 1'b0;
            bus.iframe = (k == ph_data.size() - 1);
            bus.i_ad   = ph_data[k];
            bus.CBE    = ph_be[k];
            for (int b = 0; b < 4; b++)
                if (ph_be[k][b]) model[(off + k) % DEPTH][8*b +: 8] = ph_data[k][8*b +: 8];
            tick();
        end
        backoff_check();
    endtask

    task automatic read_txn(input logic [31:0] a);
        int off;
        off = int'(a) - BASE;
        addr_phase(a, 4'b0000, 1'b1, 1'b0);
        bus.i_ad_en = 1'b0;
        bus.iframe  = 1'b0;
        bus.iready  = 1'b1;
        check("rturn_ad_en", 32'(bus.t_ad_en), 32'd0);
        check("rturn_tready", 32'(bus.tready), 32'd1);
        tick();
        for (int k = 0; k < ph_wait.size(); k++) begin
            rd_q.push_back(model[(off + k) % DEPTH]);
            for (int w = 0; w < ph_wait[k]; w++) begin
                bus.iframe = 1'b0;
                bus.iready = 1'b1;
                tick();
            end
            bus.iready = 1'b0;
            bus.iframe = (k == ph_wait.size() - 1);
            tick();
        end
        backoff_check();
    endtask

    task automatic miss_txn(input logic [31:0] a, input logic [3:0] cmd);
        addr_phase(a, cmd, 1'b0, 1'b0);
        idle_bus();
        check_released("miss_released");
        tick();
    endtask

    task automatic set_phases(input int n, input bit rnd);
        ph_data.delete();
        ph_be.delete();
        ph_wait.delete();
        for (int k = 0; k < n; k++) begin
            ph_data.push_back($urandom);
            ph_be.push_back(rnd ? 4'($urandom) : 4'hF);
            ph_wait.push_back(rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle_bus();
        clear_model();
        tick();
        tick();
        check_released("reset_state");
        rst = 1'b0;
        verify_mem();
        tick();

        // Single write at word 22
        ph_data = '{32'hDEADBEEF};
        ph_be   = '{4'b1111};
        ph_wait = '{0};
        write_txn(32'd22);
        verify_mem();

        // Asynchronous reset in the middle of a write burst
        addr_phase(32'd20, 4'b1000, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_released("async_reset");
        clear_model();
        verify_mem();
        idle_bus();
        tick();
        rst = 1'b0;
        tick();

        // Burst with partial byte enables and a wait state before the last phase
        ph_data = '{32'h11111111, 32'hAABBCCDD};
        ph_be   = '{4'b1111, 4'b0011};
        ph_wait = '{0, 1};
        write_txn(32'd20);
        verify_mem();

        // Preload across the wrap, then read back across it
        ph_data = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        ph_be   = '{4'b1111, 4'b1111};
        ph_wait = '{0, 0};
        write_txn(32'd35);
        ph_wait = '{0, 1};
        read_txn(32'd35);
        verify_mem();

        miss_txn(32'd19, 4'b1000);
        miss_txn(32'd36, 4'b0000);
        miss_txn(32'd20, 4'b0110);
        verify_mem();

        // Initiator abort: iframe and iready both high in the first data phase
        addr_phase(32'd20, 4'b1000, 1'b1, 1'b1);
        bus.iframe = 1'b1;
        bus.iready = 1'b1;
        bus.i_ad   = 32'hFFFFFFFF;
        bus.CBE    = 4'hF;
        tick();
        backoff_check();
        verify_mem();

        for (int t = 0; t < 40; t++) begin
            int kind;
            logic [31:0] a;
            logic [3:0]  cmd;
            kind = int'($urandom_range(0, 3));
            a    = 32'(BASE + int'($urandom_range(0, DEPTH - 1)));
            if (kind <= 1) begin
                set_phases(int'($urandom_range(1, 5)), 1'b1);
                write_txn(a);
            end else if (kind == 2) begin
                set_phases(int'($urandom_range(1, 5)), 1'b1);
                read_txn(a);
            end else begin
                case ($urandom_range(0, 2))
                    0: miss_txn(32'(BASE - 1 - int'($urandom_range(0, 4))), 4'b1000);
                    1: miss_txn(32'(BASE + DEPTH + int'($urandom_range(0, 4))), 4'b0000);
                    default: begin
                        do cmd = 4'($urandom); while (cmd == 4'b1000 || cmd == 4'b0000);
                        miss_txn(a, cmd);
                    end
                endcase
            end
            verify_mem();
        end

        // Asynchronous reset during a read burst
        addr_phase(32'd20, 4'b0000, 1'b1, 1'b0);
        bus.i_ad_en = 1'b0;
        bus.iframe  = 1'b0;
        bus.iready  = 1'b1;
        tick();
        rd_q.push_back(model[0]);
        bus.iready = 1'b0;
        tick();
        bus.iready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_released("reset_in_rdata");
        clear_model();
        verify_mem();
        idle_bus();
        tick();
        rst = 1'b0;
        tick();

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("claim_q_drained", 32'(claim_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
